spi_cmd_ctrl: RTL and testbench

- Command sequencer behind the SPI slave byte interface.
- Decodes the first byte of each SSEL frame as a command.
- Turns later bytes into transactions on a simple internal register bus:
  - write bursts from MOSI,
  - prefetched read bursts that feed byte_send for MISO.
- Handles burst address auto-increment, bus timeout and SPI overrun detection.

---
 rtl/spi_cmd_ctrl.sv | 127 ++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind an SPI slave byte interface: decodes the first byte of
// each frame and turns later bytes into write bursts or prefetched read bursts.
module spi_cmd_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ssel_active,
  input  logic              byte_received,
  input  logic [7:0]        byte_data_received,
  output logic [7:0]        byte_send,
  output logic              byte_send_ready,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic              reg_ack,
  input  logic [7:0]        reg_rdata,
  input  logic              err_clr,
  output logic              err_overrun,
  output logic              err_timeout,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_WAIT, WR_BUS, RD_BUS, RD_WAIT, DRAIN
  } state_t;

  state_t      state, next_state;
  logic        auto_inc;
  logic [7:0]  tmo_cnt;
  logic        frame_end;
  logic        bus_state;
  logic        tmo_hit;
  logic        bus_done;
  logic        next_req;

  assign frame_end = !ssel_active &&
                     (state inside {CMD, WR_WAIT, WR_BUS, RD_BUS, RD_WAIT});
  assign bus_state = state inside {WR_BUS, RD_BUS, DRAIN};
  assign tmo_hit   = bus_state && !reg_ack && (tmo_cnt == 8'(TIMEOUT - 1));
  assign bus_done  = bus_state && (reg_ack || tmo_hit);
  assign next_req  = next_state inside {WR_BUS, RD_BUS, DRAIN};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ssel_active)   next_state = CMD;
      CMD:     if (byte_received) next_state = byte_data_received[7] ? RD_BUS : WR_WAIT;
      WR_WAIT: if (byte_received) next_state = WR_BUS;
      WR_BUS:  if (bus_done)      next_state = WR_WAIT;
      RD_BUS:  if (bus_done)      next_state = RD_WAIT;
      RD_WAIT: if (byte_received) next_state = RD_BUS;
      DRAIN:   if (bus_done)      next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
    // An outstanding request is never abandoned; it finishes in DRAIN.
    if (frame_end) next_state = (bus_state && !bus_done) ? DRAIN : IDLE;
  end

  // NOTE: all registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_send       <= 8'h00;
      byte_send_ready <= 1'b0;
      reg_req         <= 1'b0;
      reg_we          <= 1'b0;
      reg_addr        <= '0;
      reg_wdata       <= 8'h00;
      err_overrun     <= 1'b0;
      err_timeout     <= 1'b0;
      frame_done      <= 1'b0;
      auto_inc        <= 1'b0;
      tmo_cnt         <= 8'h00;
    end else begin
      reg_req    <= next_req;
      reg_we     <= (next_state == WR_BUS) ||
                    (next_state == DRAIN && (state == WR_BUS || reg_we));
      frame_done <= (state != IDLE) && (next_state == IDLE);
      tmo_cnt    <= (bus_state && !reg_ack && !tmo_hit) ? tmo_cnt + 8'd1 : 8'd0;

      if (ssel_active) begin
        if (state == CMD && byte_received) begin
          auto_inc <= byte_data_received[6];
          reg_addr <= byte_data_received[ADDR_W-1:0];
        end
        if (state == WR_WAIT && byte_received)
          reg_wdata <= byte_data_received;
        if (state == WR_BUS && reg_ack)
          reg_addr <= reg_addr + ADDR_W'(auto_inc);
        if (state == RD_BUS) begin
          if (reg_ack) begin
            byte_send       <= reg_rdata;
            byte_send_ready <= 1'b1;
          end else if (tmo_hit) begin
            byte_send       <= 8'hFF;
            byte_send_ready <= 1'b1;
          end
        end
        if (state == RD_WAIT && byte_received) begin
          byte_send_ready <= 1'b0;
          reg_addr        <= reg_addr + ADDR_W'(auto_inc);
        end
      end

      if (frame_end) begin
        byte_send       <= 8'h00;
        byte_send_ready <= 1'b0;
      end

      // A new error event takes priority over a simultaneous clear.
      err_timeout <= tmo_hit || (err_timeout && !err_clr);
      err_overrun <= (byte_received && (state inside {WR_BUS, RD_BUS})) ||
                     (err_overrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: bus operations and read bytes are
// queued as expectations when stimulus is driven and matched as the DUT produces them.
module tb_spi_cmd_ctrl;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ssel_active;
  logic              byte_received;
  logic [7:0]        byte_data_received;
  logic [7:0]        byte_send;
  logic              byte_send_ready;
  logic              reg_req;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_ack;
  logic [7:0]        reg_rdata;
  logic              err_clr;
  logic              err_overrun;
  logic              err_timeout;
  logic              frame_done;

  spi_cmd_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .ssel_active(ssel_active),
    .byte_received(byte_received), .byte_data_received(byte_data_received),
    .byte_send(byte_send), .byte_send_ready(byte_send_ready),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .err_clr(err_clr),
    .err_overrun(err_overrun), .err_timeout(err_timeout), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } bus_op_t;

  typedef struct packed {
    logic [7:0] data;
    logic       after_ack;
  } rd_exp_t;

  bus_op_t bus_q[$];
  rd_exp_t rd_q[$];
  int      n_cmp = 0;
  int      n_err = 0;
  int      n_frames = 0;
  int      ack_cnt = 0;
  bit      ack_en = 1'b1;
  logic    prev_ack = 1'b0;
  logic    prev_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register bus responder: acks on the second cycle of a request, returns 8'h10+addr.
  initial begin
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (reg_ack) begin
        reg_ack = 1'b0;
        ack_cnt = 0;
      end else if (reg_req && ack_en) begin
        ack_cnt++;
        if (ack_cnt >= 2) begin
          reg_ack   = 1'b1;
          reg_rdata = 8'h10 + 8'(reg_addr);
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Output monitor: pops expectations on bus completions and read-data arrivals.
  initial begin
    forever begin
      bus_op_t op;
      rd_exp_t e;
      @(negedge clk);
      if (reset_n) begin
        if (reg_req && reg_ack) begin
          check("bus_op_expected", 32'(bus_q.size() != 0), 1);
          if (bus_q.size() != 0) begin
            op = bus_q.pop_front();
            check("bus_we", 32'(reg_we), 32'(op.we));
            check("bus_addr", 32'(reg_addr), 32'(op.addr));
            if (op.we) check("bus_wdata", 32'(reg_wdata), 32'(op.wdata));
          end
        end
        if (byte_send_ready && !prev_ready) begin
          check("rd_expected", 32'(rd_q.size() != 0), 1);
          if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            check("rd_data", 32'(byte_send), 32'(e.data));
            if (e.after_ack) check("rd_ready_after_ack", 32'(prev_ack), 1);
          end
        end
        if (frame_done) n_frames++;
      end
      prev_ack   = reg_ack;
      prev_ready = byte_send_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_data_received = b;
    byte_received      = 1'b1;
    tick(1);
    byte_received      = 1'b0;
    tick(gap);
  endtask

  task automatic start_frame();
    ssel_active = 1'b1;
    tick(2);
  endtask

  task automatic end_frame();
    ssel_active = 1'b0;
    tick(4);
  endtask

  task automatic push_bus(input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] wdata);
    bus_op_t op;
    op.we = we; op.addr = addr; op.wdata = wdata;
    bus_q.push_back(op);
  endtask

  task automatic push_rd(input logic [7:0] data, input logic after_ack);
    rd_exp_t e;
    e.data = data; e.after_ack = after_ack;
    rd_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_n            = 1'b0;
    ssel_active        = 1'b0;
    byte_received      = 1'b0;
    byte_data_received = 8'h00;
    err_clr            = 1'b0;
    tick(3);
    check("rst_byte_send", 32'(byte_send), 32'h00);
    check("rst_ready", 32'(byte_send_ready), 0);
    check("rst_req", 32'(reg_req), 0);
    check("rst_we", 32'(reg_we), 0);
    check("rst_addr", 32'(reg_addr), 0);
    check("rst_errs", {30'd0, err_overrun, err_timeout}, 0);
    check("rst_frame_done", 32'(frame_done), 0);
    reset_n = 1'b1;
    tick(2);

    // Write burst with auto-increment
    push_bus(1'b1, 6'd5, 8'hA1);
    push_bus(1'b1, 6'd6, 8'hB2);
    push_bus(1'b1, 6'd7, 8'hC3);
    start_frame();
    send_byte(8'h45, 3);
    send_byte(8'hA1, 6);
    send_byte(8'hB2, 6);
    send_byte(8'hC3, 6);
    end_frame();
    check("wr_frame_done", 32'(n_frames), 1);

    // Read burst with auto-increment
    for (int a = 2; a <= 4; a++) begin
      push_bus(1'b0, 6'(a), 8'h00);
      push_rd(8'h10 + 8'(a), 1'b1);
    end
    start_frame();
    send_byte(8'hC2, 6);
    check("rd_first_byte", 32'(byte_send), 32'h12);
    send_byte(8'h00, 6);
    send_byte(8'h00, 6);
    check("rd_last_byte", 32'(byte_send), 32'h14);
    end_frame();
    check("rd_end_byte_send", 32'(byte_send), 32'h00);

    // Fixed-address read
    for (int i = 0; i < 3; i++) begin
      push_bus(1'b0, 6'd3, 8'h00);
      push_rd(8'h13, 1'b1);
    end
    start_frame();
    send_byte(8'h83, 6);
    send_byte(8'h00, 6);
    send_byte(8'h00, 6);
    end_frame();

    // Address wrap
    push_bus(1'b1, 6'd63, 8'h11);
    push_bus(1'b1, 6'd0, 8'h22);
    start_frame();
    send_byte(8'h7F, 3);
    send_byte(8'h11, 6);
    send_byte(8'h22, 6);
    end_frame();

    // Byte received in IDLE is ignored
    send_byte(8'hC5, 3);
    check("idle_byte_req", 32'(reg_req), 0);
    check("idle_byte_overrun", 32'(err_overrun), 0);

    // Read timeout
    ack_en = 1'b0;
    push_rd(8'hFF, 1'b0);
    start_frame();
    send_byte(8'h81, 0);
    n = 0;
    while (reg_req && n < 40) begin
      n++;
      tick(1);
    end
    check("tmo_req_cycles", n, 15);
    check("tmo_err", 32'(err_timeout), 1);
    check("tmo_byte_send", 32'(byte_send), 32'hFF);
    check("tmo_ready", 32'(byte_send_ready), 1);
    end_frame();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("tmo_err_clr", 32'(err_timeout), 0);

    // Overrun and frame end with a pending request
    push_bus(1'b1, 6'd8, 8'h5A);
    start_frame();
    send_byte(8'h08, 2);
    send_byte(8'h5A, 1);
    send_byte(8'h77, 1);
    check("ovr_err", 32'(err_overrun), 1);
    ssel_active = 1'b0;
    tick(3);
    check("drain_req_held", 32'(reg_req), 1);
    check("drain_we_held", 32'(reg_we), 1);
    ack_en = 1'b1;
    tick(6);
    check("drain_req_done", 32'(reg_req), 0);
    check("drain_byte_send", 32'(byte_send), 32'h00);
    check("drain_no_timeout", 32'(err_timeout), 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ovr_err_clr", 32'(err_overrun), 0);

    tick(2);
    check("bus_q_drained", bus_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("frame_count", n_frames, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
